// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, status/control registers and a level TX-done IRQ.
// Latency: bus response (rvalid/rdata) one cycle after grant; first start bit one cycle after the pop decision.
// Backpressure: none on the bus (gnt = req); a write to a full FIFO with no pop that cycle drops the byte and sets overflow.
// Optional build macro UART_TX_PARITY_EN adds CTRL parity_en/parity_odd and a PARITY bit between DATA and STOP.

// Generic synchronous FIFO, combinational head, push accepted when full if a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [Width-1:0]           i_dat,
  output logic [Width-1:0]           o_dat,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(Depth):0]     o_level
);
  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [LvlW-1:0]  r_level;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_level == LvlW'(Depth));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dat     = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointers wrap modulo Depth (power of two); level tracks occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LvlW'(1);
        2'b01:   r_level <= r_level - LvlW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

module uart_tx_periph #(
  parameter int ClkFreq   = 50000000,
  parameter int BaudRate  = 115200,
  parameter int FifoDepth = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int Div  = ClkFreq / BaudRate;
  localparam int CntW = $clog2(Div);
  localparam int LvlW = $clog2(FifoDepth) + 1;
  localparam logic [CntW-1:0] BaudMax = CntW'(Div - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Bus decode
  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_sel;
  logic        w_push_req;
  logic        w_ctrl_wr;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Registers
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_tx_en;
  logic        r_irq_en;
  logic        r_ovf;
  logic        r_irq;
  logic        w_par_en;
  logic        w_par_odd;

  // FIFO
  logic [7:0]      w_head;
  logic            w_full;
  logic            w_empty;
  logic [LvlW-1:0] w_level;
  logic            w_pop;

  // Transmit FSM and datapath
  state_t          r_state;
  state_t          w_state_n;
  logic [CntW-1:0] r_baud;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_n;
  logic            r_dpar;
  logic            r_tx;
  logic            w_tx_n;
  logic            w_baud_end;
  logic            w_active;

  assign w_wr       = req_i & we_i;
  assign w_rd       = req_i & ~we_i;
  assign w_sel      = addr_i[3:2];
  assign w_push_req = w_wr & (w_sel == 2'd0);
  assign w_ctrl_wr  = w_wr & (w_sel == 2'd2);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_ovf_clr  = w_wr & (w_sel == 2'd1) & wdata_i[3];
  assign w_unused   = ^{wdata_i[31:8], addr_i[1:0]};

  assign w_active   = (r_state != S_IDLE);
  assign w_baud_end = (r_baud == BaudMax);

  assign gnt_o    = req_i;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign tx_o     = r_tx;
  assign irq_o    = r_irq;

  uart_tx_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_dat   (wdata_i[7:0]),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_odd;

  // Parity controls live in CTRL bits 2 and 3.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_par_en  <= wdata_i[2];
      r_par_odd <= wdata_i[3];
    end
  end

  assign w_par_en  = r_par_en;
  assign w_par_odd = r_par_odd;
`else
  assign w_par_en  = 1'b0;
  assign w_par_odd = 1'b0;
`endif

  // Read mux: writes and unmapped offsets return zero.
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_sel)
        2'd1: begin
          w_rdata[0]    = w_full;
          w_rdata[1]    = w_empty;
          w_rdata[2]    = w_active;
          w_rdata[3]    = r_ovf;
          w_rdata[15:8] = 8'(w_level);
        end
        2'd2: begin
          w_rdata[0] = r_tx_en;
          w_rdata[1] = r_irq_en;
          w_rdata[2] = w_par_en;
          w_rdata[3] = w_par_odd;
        end
        default: w_rdata = '0;
      endcase
    end
  end

  // One-cycle registered response for every granted access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= w_rdata;
    end
  end

  // CTRL enable bits; tx_en defaults on so the console works without setup.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_en  <= 1'b1;
      r_irq_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_tx_en  <= wdata_i[0];
      r_irq_en <= wdata_i[1];
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // FSM next state and pop decision; a pop happens only when entering START.
  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_tx_en && !w_empty) begin
          w_pop     = 1'b1;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) w_state_n = S_DATA;
      end
      S_DATA: begin
        if (w_baud_end && (r_bitcnt == 3'd7)) begin
          w_state_n = w_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_baud_end) w_state_n = S_STOP;
      end
      S_STOP: begin
        if (w_baud_end) begin
          if (r_tx_en && !w_empty) begin
            w_pop     = 1'b1;
            w_state_n = S_START;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Next shift contents and next line level, so tx_o changes on the same edge as the state.
  always_comb begin
    w_shift_n = r_shift;
    if (w_pop) begin
      w_shift_n = w_head;
    end else if ((r_state == S_DATA) && w_baud_end) begin
      w_shift_n = {1'b0, r_shift[7:1]};
    end
    w_tx_n = 1'b1;
    case (w_state_n)
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_shift_n[0];
      S_PARITY: w_tx_n = r_dpar ^ w_par_odd;
      default:  w_tx_n = 1'b1;
    endcase
  end

  // Baud/bit counters, shift register, latched data parity and the registered line driver.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_dpar   <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      if ((w_state_n != r_state) || w_baud_end || (r_state == S_IDLE)) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + CntW'(1);
      end
      if (r_state != S_DATA) begin
        r_bitcnt <= '0;
      end else if (w_baud_end) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      r_shift <= w_shift_n;
      if (w_pop) begin
        r_dpar <= ^w_head;
      end
      r_tx <= w_tx_n;
    end
  end

  // TX-done interrupt: enabled, nothing queued and the line idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & w_empty & ~w_active;
    end
  end
endmodule
